lfsr_led_pwm: RTL and testbench

Downstream consumer of the 4-bit LFSR generator.
- Accepts pseudo-random values over a valid/ready handshake.
- Uses each value as a PWM duty cycle to drive the board LED, so the LED flickers at random brightness levels.
- Requests a new value only after a programmable number of PWM frames. The LFSR therefore advances at a human-visible rate instead of every clock.

---
 rtl/lfsr_led_pkg.sv | 16 +
 rtl/pwm_tick_gen.sv | 24 ++
 rtl/lfsr_led_pwm.sv | 96 +++++++++
 tb/tb_lfsr_led_pwm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_led_pkg.sv
// Shared types and helpers for the LFSR-driven LED PWM block.
package lfsr_led_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUN,
    REQ,
    HOLD
  } state_e;

  // Number of PWM slots per frame for a duty value of the given width.
  function automatic int slots(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE clocks while enabled, counter held at 0 otherwise.
module pwm_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_pre_cnt;

  assign tick = en && (r_pre_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_pre_cnt <= '0;
    else if (!en || tick)    r_pre_cnt <= '0;
    else                     r_pre_cnt <= r_pre_cnt + 1'b1;
  end

endmodule

// File: rtl/lfsr_led_pwm.sv
// Consumes random values over valid/ready and uses each one as the LED PWM duty
// for FRAMES_PER_VALUE frames; duty only ever changes on a frame boundary.
module lfsr_led_pwm
  import lfsr_led_pkg::*;
#(
  parameter int WIDTH            = 4,
  parameter int PRESCALE         = 50000,
  parameter int FRAMES_PER_VALUE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rand_data,
  input  logic             rand_valid,
  output logic             rand_ready,
  output logic             led,
  output logic             frame_done
);

  localparam int               SLOTS      = slots(WIDTH);
  localparam int               FW         = (FRAMES_PER_VALUE > 1) ? $clog2(FRAMES_PER_VALUE) : 1;
  localparam logic [WIDTH-1:0] SLOT_LAST  = WIDTH'(SLOTS - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAMES_PER_VALUE - 1);

  state_e           r_state, w_next_state;
  logic [WIDTH-1:0] r_slot, r_duty, r_pending;
  logic [FW-1:0]    r_frame_cnt;
  logic             w_run, w_tick, w_frame_end, w_hs, w_last_frame;

  assign w_run        = (r_state != WAIT_FIRST);
  assign w_frame_end  = w_tick && (r_slot == SLOT_LAST);
  assign w_hs         = rand_valid && rand_ready;
  assign w_last_frame = (r_frame_cnt == FRAME_LAST);

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_run),
    .tick (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_FIRST: if (w_hs) w_next_state = RUN;
      RUN:        if (w_frame_end && w_last_frame) w_next_state = REQ;
      REQ:        if (w_hs) w_next_state = w_frame_end ? RUN : HOLD;
      HOLD:       if (w_frame_end) w_next_state = RUN;
      default:    w_next_state = WAIT_FIRST;
    endcase
  end

  // rand_ready follows the next state so it drops on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= WAIT_FIRST;
      rand_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      rand_ready <= (w_next_state == WAIT_FIRST) || (w_next_state == REQ);
    end
  end

  // A value taken mid-frame is parked in r_pending until the frame closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty    <= '0;
      r_pending <= '0;
    end else begin
      if (w_hs && (r_state == WAIT_FIRST || w_frame_end)) r_duty <= rand_data;
      else if (r_state == HOLD && w_frame_end)            r_duty <= r_pending;
      if (w_hs && r_state == REQ && !w_frame_end)         r_pending <= rand_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot      <= '0;
      r_frame_cnt <= '0;
      led         <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (!w_run) begin
        r_slot      <= '0;
        r_frame_cnt <= '0;
        led         <= 1'b0;
      end else begin
        led <= (r_slot < r_duty);
        if (w_tick) r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
        if (r_state == RUN && w_frame_end)
          r_frame_cnt <= w_last_frame ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_led_pwm.sv
// Bench for lfsr_led_pwm: per-frame led-high counts are queued as values are sent
// and checked by a frame monitor at every frame_done pulse.
module tb_lfsr_led_pwm;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 2;
  localparam int FPV      = 2;
  localparam int FRAME    = 30;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] rand_data = '0;
  logic             rand_valid = 1'b0;
  logic             rand_ready, led, frame_done;

  int n_run = 0;
  int n_fail = 0;
  int exp_q[$];
  int frames_seen = 0;
  int clear_req = 0;

  always #5 clk = ~clk;

  lfsr_led_pwm #(
    .WIDTH            (WIDTH),
    .PRESCALE         (PRESCALE),
    .FRAMES_PER_VALUE (FPV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rand_data  (rand_data),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .led        (led),
    .frame_done (frame_done)
  );

  // Counts led-high cycles and frame length between frame_done pulses.
  task automatic monitor_frames();
    int hi = 0, len = 0, ack = 0, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hi = 0; len = 0; ack = clear_req;
        continue;
      end
      if (ack != clear_req) begin
        hi = 0; len = 0; ack = clear_req;
      end
      hi += int'(led);
      if (frame_done === 1'b1) begin
        frames_seen++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: frame %0d had %0d led-high cycles, none expected", frames_seen, hi);
        end else begin
          e = exp_q.pop_front();
          if (hi !== e) begin
            n_fail++;
            $display("FAIL frame_duty: frame %0d led high %0d cycles, expected %0d", frames_seen, hi, e);
          end
        end
        n_run++;
        if (len !== FRAME) begin
          n_fail++;
          $display("FAIL frame_len: frame %0d lasted %0d cycles, expected %0d", frames_seen, len, FRAME);
        end
        hi = 0; len = 0;
      end
      len++;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input bit fresh, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rand_ready === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) return;
    @(negedge clk);
    rand_valid = 1'b1; rand_data = v;
    @(posedge clk); #1;
    rand_valid = 1'b0; rand_data = WIDTH'($urandom);
    if (fresh) clear_req++;
  endtask

  task automatic wait_ready(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (rand_ready !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (rand_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0; rand_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_run++; if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b, expected 0", led); end
    n_run++; if (rand_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", rand_ready); end
    n_run++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++; if (rand_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b, expected 1", rand_ready); end
  endtask

  task automatic test_duty5();
    bit ok; int cyc;
    send(4'h5, 1'b1, ok);
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_5: ready timeout"); end
    exp_q.push_back(10); exp_q.push_back(10);
    n_run++; if (rand_ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop_5: got %b, expected 0", rand_ready); end
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || cyc != 2 * FRAME) begin
      n_fail++; $display("FAIL value_period: ready after %0d cycles (ok=%0d), expected %0d", cyc, ok, 2 * FRAME);
    end
  endtask

  task automatic test_extremes();
    bit ok; int cyc, f0;
    send(4'h0, 1'b0, ok);
    f0 = frames_seen;
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_0: ready timeout"); end
    exp_q.push_back(10); exp_q.push_back(0); exp_q.push_back(0);
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || frames_seen - f0 != 2) begin
      n_fail++; $display("FAIL req_after_0: %0d frames before ready (ok=%0d), expected 2", frames_seen - f0, ok);
    end
    send(4'hF, 1'b0, ok);
    f0 = frames_seen;
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_F: ready timeout"); end
    exp_q.push_back(0); exp_q.push_back(30); exp_q.push_back(30);
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || frames_seen - f0 != 2) begin
      n_fail++; $display("FAIL req_after_F: %0d frames before ready (ok=%0d), expected 2", frames_seen - f0, ok);
    end
  endtask

  task automatic test_midframe();
    bit ok; int cyc, f0;
    repeat (10) @(posedge clk);
    #1;
    send(4'hA, 1'b0, ok);
    f0 = frames_seen;
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_A: ready timeout"); end
    exp_q.push_back(30); exp_q.push_back(20); exp_q.push_back(20);
    n_run++; if (rand_ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop_A: got %b, expected 0", rand_ready); end
    repeat (12) @(posedge clk);
    #1;
    n_run++; if (led !== 1'b1) begin n_fail++; $display("FAIL old_duty_held: led %b at slot 11, expected 1", led); end
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || frames_seen - f0 != 2) begin
      n_fail++; $display("FAIL req_after_A: %0d frames before ready (ok=%0d), expected 2", frames_seen - f0, ok);
    end
  endtask

  task automatic test_starve();
    bit ok; int cyc, f0, bad;
    exp_q.push_back(20); exp_q.push_back(20); exp_q.push_back(20);
    bad = 0;
    repeat (3 * FRAME) begin
      @(posedge clk); #1;
      if (rand_ready !== 1'b1) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL starve_ready: ready low %0d cycles, expected 0", bad); end
    repeat (10) @(posedge clk);
    #1;
    send(4'h3, 1'b0, ok);
    f0 = frames_seen;
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_3: ready timeout"); end
    exp_q.push_back(20); exp_q.push_back(6); exp_q.push_back(6);
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || frames_seen - f0 != 2) begin
      n_fail++; $display("FAIL req_after_starve: %0d frames before ready (ok=%0d), expected 2", frames_seen - f0, ok);
    end
  endtask

  // Handshake placed exactly on the frame_end cycle: new duty applies next frame.
  task automatic test_back_to_back();
    exp_q.push_back(6);
    repeat (FRAME - 1) @(posedge clk);
    @(negedge clk);
    rand_valid = 1'b1; rand_data = 4'h7;
    @(posedge clk); #1;
    rand_valid = 1'b0; rand_data = WIDTH'($urandom);
    exp_q.push_back(14); exp_q.push_back(14);
    n_run++; if (rand_ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop_edge: got %b, expected 0", rand_ready); end
  endtask

  task automatic test_async_reset();
    bit ok; int cyc;
    repeat (5) @(posedge clk);
    #3;
    n_run++; if (led !== 1'b1) begin n_fail++; $display("FAIL led_before_reset: got %b, expected 1", led); end
    rst = 1'b0;
    #1;
    n_run++; if (led !== 1'b0) begin n_fail++; $display("FAIL async_led: got %b, expected 0", led); end
    n_run++; if (rand_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %b, expected 0", rand_ready); end
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_run++; if (rand_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_async: got %b, expected 1", rand_ready); end
    n_run++; if (led !== 1'b0) begin n_fail++; $display("FAIL led_wait_first: got %b, expected 0", led); end
    send(4'hC, 1'b1, ok);
    n_run++; if (!ok) begin n_fail++; $display("FAIL send_C: ready timeout"); end
    exp_q.push_back(24); exp_q.push_back(24);
    wait_ready(200, cyc, ok);
    n_run++;
    if (!ok || cyc != 2 * FRAME) begin
      n_fail++; $display("FAIL restart_period: ready after %0d cycles (ok=%0d), expected %0d", cyc, ok, 2 * FRAME);
    end
    @(negedge clk); #1;
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    fork
      monitor_frames();
    join_none
    test_reset();
    test_duty5();
    test_extremes();
    test_midframe();
    test_starve();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
